alu_arbiter: RTL

Two-port arbiter and sequencer that shares one 32-bit ALU between two requesters, such as the integer pipeline and a multi-cycle helper unit. It accepts one operation at a time over a valid/ready request channel and drives the registered operands and opcode to the ALU. It captures the result and zero flag, then returns them on the requester's own valid/ready response channel. It sits between the requesters and the ALU instance in the datapath.

---
 rtl/alu_arbiter.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
//
// Shares one 32-bit ALU between two requesters. One operation is in flight at
// a time: a request is accepted in IDLE, its operands/opcode are registered and
// presented to the ALU for one EXEC cycle, the result and zero flag are
// captured, and the response is held on the owning requester's response
// channel until it is taken. Priority is round-robin and only flips when a
// response completes, so two continuously-valid requesters alternate while a
// lone requester is served back-to-back.
//
// Ports
//   clk, reset                 clock, asynchronous active-high reset
//   req{0,1}_valid/_ready      request handshake (ready is combinational)
//   req{0,1}_a/_b/_op          operands and ALU control code
//   rsp{0,1}_valid/_ready      response handshake (valid is registered)
//   rsp{0,1}_result/_zero      registered ALU result and zero flag
//   alu_a, alu_b, alu_control  registered operands/opcode driven to the ALU
//   alu_result, alu_zero       combinational ALU outputs
//   busy                       high whenever the FSM is not in IDLE
//
// Parameters
//   PRIO_INIT                  requester index (0 or 1) holding priority
//                              after reset
//
// state | meaning
// ------+------------------------------------------------------------------
// IDLE  | arbitrate between valid requests; an accept moves to EXEC
// EXEC  | ALU evaluates the registered operands; result/zero captured
// RESP  | rsp{id}_valid held until rsp{id}_ready, then back to IDLE
// -----------------------------------------------------------------------------
module alu_arbiter #(
    parameter int PRIO_INIT = 0
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic [2:0]  req0_op,

    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic [2:0]  req1_op,

    output logic        rsp0_valid,
    input  logic        rsp0_ready,
    output logic [31:0] rsp0_result,
    output logic        rsp0_zero,

    output logic        rsp1_valid,
    input  logic        rsp1_ready,
    output logic [31:0] rsp1_result,
    output logic        rsp1_zero,

    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [2:0]  alu_control,
    input  logic [31:0] alu_result,
    input  logic        alu_zero,

    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic PRIO_RST = (PRIO_INIT != 0);

    state_t      state;
    logic        prio;
    logic        id;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [2:0]  op_q;
    logic [31:0] result_q;
    logic        zero_q;
    logic        rsp0_valid_q;
    logic        rsp1_valid_q;
    logic        busy_q;

    logic        idle;
    logic        grant0;
    logic        grant1;
    logic        rsp_take;

    // Arbitration: a requester wins if it holds priority or the other side is
    // not asking. The two terms are mutually exclusive when both are valid.
    assign idle   = (state == IDLE);
    assign grant0 = idle & req0_valid & (~prio | ~req1_valid);
    assign grant1 = idle & req1_valid & ( prio | ~req0_valid);

    // Only the owner's ready can complete the response.
    assign rsp_take = id ? rsp1_ready : rsp0_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            prio         <= PRIO_RST;
            id           <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= '0;
            result_q     <= '0;
            zero_q       <= 1'b0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant0) begin
                        a_q    <= req0_a;
                        b_q    <= req0_b;
                        op_q   <= req0_op;
                        id     <= 1'b0;
                        busy_q <= 1'b1;
                        state  <= EXEC;
                    end else if (grant1) begin
                        a_q    <= req1_a;
                        b_q    <= req1_b;
                        op_q   <= req1_op;
                        id     <= 1'b1;
                        busy_q <= 1'b1;
                        state  <= EXEC;
                    end
                end

                EXEC: begin
                    result_q     <= alu_result;
                    zero_q       <= alu_zero;
                    rsp0_valid_q <= ~id;
                    rsp1_valid_q <=  id;
                    state        <= RESP;
                end

                RESP: begin
                    // Returning to IDLE here (rather than accepting directly)
                    // keeps a completing response and a new accept in
                    // separate cycles.
                    if (rsp_take) begin
                        rsp0_valid_q <= 1'b0;
                        rsp1_valid_q <= 1'b0;
                        prio         <= ~id;
                        busy_q       <= 1'b0;
                        state        <= IDLE;
                    end
                end

                default: begin
                    rsp0_valid_q <= 1'b0;
                    rsp1_valid_q <= 1'b0;
                    busy_q       <= 1'b0;
                    state        <= IDLE;
                end
            endcase
        end
    end

    assign req0_ready  = grant0;
    assign req1_ready  = grant1;

    assign rsp0_valid  = rsp0_valid_q;
    assign rsp1_valid  = rsp1_valid_q;
    assign rsp0_result = result_q;
    assign rsp1_result = result_q;
    assign rsp0_zero   = zero_q;
    assign rsp1_zero   = zero_q;

    assign alu_a       = a_q;
    assign alu_b       = b_q;
    assign alu_control = op_q;

    assign busy        = busy_q;

endmodule
